// File: rtl/mask_scan_ctrl.sv
// Raster scan controller producing an inclusive rectangular window mask per pixel.
// Optional MASK_CTRL_SHADOW_EN: window writes land in shadow registers, loaded at frame start.
module mask_scan_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int HBLANK_CYC = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSTART,
  input  logic       iPAUSE,
  input  logic       iCFG_WR,
  input  logic [1:0] iCFG_ADDR,
  input  logic [9:0] iCFG_DATA,
  output logic       oMASK_VAL,
  output logic       oMASK,
  output logic [9:0] oMASK_X,
  output logic [9:0] oMASK_Y,
  output logic       oBUSY,
  output logic       oFRAME_DONE,
  output logic [1:0] oDBG_STATE
);

  typedef enum logic [1:0] {IDLE, SCAN, HBLANK, DONE} state_t;

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);
  localparam logic [7:0] B_LAST = 8'(HBLANK_CYC - 1);

  // Window layout: [0]=X0, [1]=Y0, [2]=X1, [3]=Y1.
  state_t          state, stateN;
  logic [9:0]      x, xN, y, yN;
  logic [7:0]      bcnt, bcntN;
  logic [3:0][9:0] win, winN, winWr, eff;
  logic            valN, maskN, busyN, doneN;
  logic [9:0]      mxN, myN, px, py;
  logic            present, startAcc;

  // oBUSY is still high during the frame-done cycle, which blocks a start there.
  assign startAcc   = (state == IDLE) && iSTART && !oBUSY;
  assign oDBG_STATE = state;

`ifdef MASK_CTRL_SHADOW_EN
  logic [3:0][9:0] shadow;

  always_comb begin
    winWr = shadow;
    if (iCFG_WR) winWr[iCFG_ADDR] = iCFG_DATA;
    eff  = startAcc ? shadow : win;
    winN = eff;
  end
`else
  // Writes are forwarded so the pixel presented at the write edge already sees them.
  always_comb begin
    winWr = win;
    if (iCFG_WR) winWr[iCFG_ADDR] = iCFG_DATA;
    eff  = winWr;
    winN = winWr;
  end
`endif

  always_comb begin
    stateN  = state;
    xN      = x;
    yN      = y;
    bcntN   = bcnt;
    valN    = 1'b0;
    maskN   = oMASK;
    mxN     = oMASK_X;
    myN     = oMASK_Y;
    busyN   = oBUSY;
    doneN   = 1'b0;
    present = 1'b0;
    px      = x;
    py      = y;
    case (state)
      IDLE: begin
        busyN = 1'b0;
        if (startAcc) begin
          present = 1'b1;
          px      = '0;
          py      = '0;
          busyN   = 1'b1;
        end
      end
      SCAN: begin
        if (!iPAUSE) present = 1'b1;
      end
      HBLANK: begin
        if (!iPAUSE) begin
          if (bcnt == B_LAST) begin
            stateN = SCAN;
            bcntN  = '0;
          end else begin
            bcntN = bcnt + 8'd1;
          end
        end
      end
      DONE: begin
        doneN  = 1'b1;
        stateN = IDLE;
      end
      default: stateN = IDLE;
    endcase

    if (present) begin
      valN  = 1'b1;
      mxN   = px;
      myN   = py;
      maskN = (px >= eff[0]) && (px <= eff[2]) && (py >= eff[1]) && (py <= eff[3]);
      if (px == X_LAST) begin
        xN = '0;
        yN = py;
        if (py == Y_LAST) begin
          stateN = DONE;
        end else begin
          yN     = py + 10'd1;
          stateN = HBLANK;
          bcntN  = '0;
        end
      end else begin
        xN     = px + 10'd1;
        yN     = py;
        stateN = SCAN;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      bcnt        <= '0;
      win         <= '0;
`ifdef MASK_CTRL_SHADOW_EN
      shadow      <= '0;
`endif
      oMASK_VAL   <= 1'b0;
      oMASK       <= 1'b0;
      oMASK_X     <= '0;
      oMASK_Y     <= '0;
      oBUSY       <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      state       <= stateN;
      x           <= xN;
      y           <= yN;
      bcnt        <= bcntN;
      win         <= winN;
`ifdef MASK_CTRL_SHADOW_EN
      shadow      <= winWr;
`endif
      oMASK_VAL   <= valN;
      oMASK       <= maskN;
      oMASK_X     <= mxN;
      oMASK_Y     <= myN;
      oBUSY       <= busyN;
      oFRAME_DONE <= doneN;
    end
  end

endmodule

// File: tb/tb_mask_scan_ctrl.sv
// Directed bench for mask_scan_ctrl with an 8x4 frame and 2 blanking cycles.
// Handshake: iSTART is a level sampled only when idle; oMASK_VAL marks a presented pixel.
module tb_mask_scan_ctrl;

  logic       iCLK, iRST_N, iSTART, iPAUSE, iCFG_WR;
  logic [1:0] iCFG_ADDR;
  logic [9:0] iCFG_DATA;
  logic       oMASK_VAL, oMASK, oBUSY, oFRAME_DONE;
  logic [9:0] oMASK_X, oMASK_Y;
  logic [1:0] oDBG_STATE;

  int errCnt = 0;
  int chkCnt = 0;

  mask_scan_ctrl #(.H_ACTIVE(8), .V_ACTIVE(4), .HBLANK_CYC(2)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iPAUSE(iPAUSE),
    .iCFG_WR(iCFG_WR), .iCFG_ADDR(iCFG_ADDR), .iCFG_DATA(iCFG_DATA),
    .oMASK_VAL(oMASK_VAL), .oMASK(oMASK), .oMASK_X(oMASK_X), .oMASK_Y(oMASK_Y),
    .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE), .oDBG_STATE(oDBG_STATE)
  );

  // clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_mask(input int px, input int py,
                                    input logic [9:0] a, input logic [9:0] b,
                                    input logic [9:0] c, input logic [9:0] d);
    return (px >= a) && (px <= c) && (py >= b) && (py <= d);
  endfunction

  task automatic cfg_write(input logic [1:0] addr, input logic [9:0] data);
    @(negedge iCLK);
    iCFG_WR = 1'b1; iCFG_ADDR = addr; iCFG_DATA = data;
    @(negedge iCLK);
    iCFG_WR = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_val"},  oMASK_VAL, 0);
    check({nm, "_mask"}, oMASK, 0);
    check({nm, "_x"},    oMASK_X, 0);
    check({nm, "_y"},    oMASK_Y, 0);
    check({nm, "_busy"}, oBUSY, 0);
    check({nm, "_done"}, oFRAME_DONE, 0);
  endtask

  // mode: 0 plain, 1 start with pause, 2 pause at (4,1), 3 restart attempts,
  //       4 write X1 at (1,1), 5 reset at (3,2)
  task automatic run_frame(input string nm, input int mode,
                           input logic [9:0] w0, input logic [9:0] w1,
                           input logic [9:0] w2, input logic [9:0] w3,
                           input logic [9:0] newX1, input int chgIdx,
                           input int expOnes, input int expBusy);
    int pix, cur, ones, busyCnt, doneCnt, gap, pauseLeft;
    logic pausedPrev, prevLast, finished, aborted;
    logic [9:0] ex1;
    pix = 0; ones = 0; busyCnt = 0; doneCnt = 0; gap = 0; pauseLeft = 0;
    pausedPrev = 0; prevLast = 0; finished = 0; aborted = 0;
    @(negedge iCLK);
    iSTART = 1'b1;
    iPAUSE = (mode == 1);
    for (int cyc = 0; cyc < 150 && !finished; cyc++) begin
      @(negedge iCLK);
      iSTART = 1'b0;
      iCFG_WR = 1'b0;
      if (pausedPrev) begin
        check({nm, "_pause_val"}, oMASK_VAL, 0);
        check({nm, "_pause_x"}, oMASK_X, 3);
        check({nm, "_pause_y"}, oMASK_Y, 1);
      end
      cur = -1;
      if (oMASK_VAL) begin
        cur = pix;
        ex1 = (pix >= chgIdx) ? newX1 : w2;
        check({nm, "_x"}, oMASK_X, pix % 8);
        check({nm, "_y"}, oMASK_Y, pix / 8);
        check({nm, "_mask"}, oMASK, exp_mask(pix % 8, pix / 8, w0, w1, ex1, w3));
        if (pix % 8 == 0 && pix > 0) check({nm, "_hblank"}, gap, 2);
        ones += oMASK;
        gap = 0;
        pix++;
      end else if (oBUSY) begin
        gap++;
      end
      if (oBUSY) busyCnt++;
      if (oFRAME_DONE) begin
        doneCnt++;
        check({nm, "_done_after_last"}, prevLast, 1);
        if (mode == 3) iSTART = 1'b1;
      end
      prevLast = oMASK_VAL && (pix == 32);
      if (!oBUSY) finished = 1;
      if (mode == 2 && cur == 11) pauseLeft = 3;
      if (mode == 3 && cur == 21) iSTART = 1'b1;
      if (mode == 4 && cur == 9) begin
        iCFG_WR = 1'b1; iCFG_ADDR = 2'd2; iCFG_DATA = newX1;
      end
      if (pauseLeft > 0) begin
        iPAUSE = 1'b1; pauseLeft--; pausedPrev = 1;
      end else begin
        iPAUSE = 1'b0; pausedPrev = 0;
      end
      if (mode == 5 && cur == 19) begin
        iRST_N = 1'b0;
        #1;
        check_zero({nm, "_async"});
        repeat (2) begin
          @(negedge iCLK);
          check({nm, "_rst_done"}, oFRAME_DONE, 0);
        end
        check({nm, "_no_done"}, doneCnt, 0);
        iRST_N = 1'b1;
        aborted = 1;
        finished = 1;
      end
    end
    if (!finished) check({nm, "_timeout"}, 1, 0);
    if (!aborted) begin
      check({nm, "_strobes"}, pix, 32);
      check({nm, "_ones"}, ones, expOnes);
      check({nm, "_busy_cyc"}, busyCnt, expBusy);
      check({nm, "_done_cnt"}, doneCnt, 1);
    end
    if (mode == 3) begin
      repeat (3) begin
        @(negedge iCLK);
        check({nm, "_idle_busy"}, oBUSY, 0);
        check({nm, "_idle_val"}, oMASK_VAL, 0);
      end
    end
  endtask

  initial begin
    iRST_N = 1'b0; iSTART = 1'b0; iPAUSE = 1'b0;
    iCFG_WR = 1'b0; iCFG_ADDR = '0; iCFG_DATA = '0;
    repeat (3) @(negedge iCLK);
    check_zero("reset");
    check("reset_state", oDBG_STATE, 0);
    iRST_N = 1'b1;
    @(negedge iCLK);
    check("idle_busy", oBUSY, 0);

    cfg_write(2'd0, 10'd2);
    cfg_write(2'd1, 10'd1);
    cfg_write(2'd2, 10'd5);
    cfg_write(2'd3, 10'd2);
    run_frame("base", 0, 2, 1, 5, 2, 5, 1000, 8, 39);
    @(negedge iCLK);
    check("hold_val", oMASK_VAL, 0);
    check("hold_x", oMASK_X, 7);
    check("hold_y", oMASK_Y, 3);

    cfg_write(2'd0, 10'd6);
    cfg_write(2'd2, 10'd3);
    run_frame("empty", 1, 6, 1, 3, 2, 3, 1000, 0, 39);

    cfg_write(2'd0, 10'd2);
    cfg_write(2'd2, 10'd5);
    run_frame("pause", 2, 2, 1, 5, 2, 5, 1000, 8, 42);
    run_frame("restart", 3, 2, 1, 5, 2, 5, 1000, 8, 39);

`ifdef MASK_CTRL_SHADOW_EN
    run_frame("wr", 4, 2, 1, 5, 2, 7, 1000, 8, 39);
`else
    run_frame("wr", 4, 2, 1, 5, 2, 7, 10, 12, 39);
`endif
    run_frame("wide", 0, 2, 1, 7, 2, 7, 1000, 12, 39);

    run_frame("abort", 5, 2, 1, 7, 2, 7, 1000, 0, 0);
    check_zero("post_rst");
    run_frame("zero", 0, 0, 0, 0, 0, 0, 1000, 1, 39);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
